regwb_arbiter: RTL

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regwb_arbiter.sv
// -----------------------------------------------------------------------------
// regwb_arbiter
//   Arbitrates two writeback requesters (ALU result, load data) onto the
//   single register-file write port. Grants are combinational (ready), the
//   write itself is registered one cycle later. Also flags decode-stage RAW
//   hazards against pending requests and the write currently in flight.
//
// Parameters
//   PRIO_MEM      0: round-robin between alu and mem, 1: mem always beats alu
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   alu_valid/reg/data, alu_ready ALU writeback request / accept
//   mem_valid/reg/data/byte,      load writeback request (byte = lb sign-ext)
//   mem_ready                     load accept
//   rf_regWrite/write_reg/        registered register-file write port
//   write_data
//   query_reg1, query_reg2        decode-stage source registers
//   hazard                        a queried register has a pending write
// -----------------------------------------------------------------------------
module regwb_arbiter #(
  parameter bit PRIO_MEM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  input  logic        mem_byte,
  output logic        mem_ready,
  output logic        rf_regWrite,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        hazard
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

  grant_e      grant;
  logic        favour_mem_q, favour_mem_d;  // round-robin pointer
  logic        regwrite_q;
  logic [4:0]  write_reg_q;
  logic [31:0] write_data_q;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  // Grant decision. Nothing is granted while reset is high so a requester
  // simply keeps holding its request across reset.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    grant = GNT_NONE;
    if (!reset) begin
      if (alu_valid && mem_valid) begin
        grant = (PRIO_MEM || favour_mem_q) ? GNT_MEM : GNT_ALU;
      end else if (alu_valid) begin
        grant = GNT_ALU;
      end else if (mem_valid) begin
        grant = GNT_MEM;
      end
    end
  end

  assign alu_ready = (grant == GNT_ALU);
  assign mem_ready = (grant == GNT_MEM);

  // Writeback payload of the granted requester; lb sign-extends the low byte.
  always_comb begin
    wr_reg  = alu_reg;
    wr_data = alu_data;
    if (grant == GNT_MEM) begin
      wr_reg  = mem_reg;
      wr_data = mem_byte ? {{24{mem_data[7]}}, mem_data[7:0]} : mem_data;
    end
  end

  // Pointer moves only on a transfer: favour whoever was not just granted.
  always_comb begin
    favour_mem_d = favour_mem_q;
    if (grant == GNT_ALU) favour_mem_d = 1'b1;
    if (grant == GNT_MEM) favour_mem_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
      favour_mem_q <= 1'b1;
    end else begin
      // x0 is hardwired zero: accept the transfer but never strobe it.
      regwrite_q   <= (grant != GNT_NONE) && (wr_reg != 5'd0);
      favour_mem_q <= favour_mem_d;
      if (grant != GNT_NONE) begin
        write_reg_q  <= wr_reg;
        write_data_q <= wr_data;
      end
    end
  end

  assign rf_regWrite   = regwrite_q;
  assign rf_write_reg  = write_reg_q;
  assign rf_write_data = write_data_q;

  // A source register is hazardous if any write to it is still pending at a
  // requester or is being written this cycle. x0 never carries a hazard.
  function automatic logic reg_hit(input logic [4:0] q);
    return (q != 5'd0) &&
           ((alu_valid   && (q == alu_reg)) ||
            (mem_valid   && (q == mem_reg)) ||
            (regwrite_q  && (q == write_reg_q)));
  endfunction

  assign hazard = reg_hit(query_reg1) || reg_hit(query_reg2);

endmodule
